// File: rtl/aig_sweep_pkg.sv
// Shared types and constants for the exhaustive 4-input vector sweeper and its MISR.
package aig_sweep_pkg;

  localparam int unsigned MisrWidth = 16;
  localparam int unsigned VecWidth  = 4;
  localparam int unsigned RespWidth = 13;

  // x^16 + x^12 + x^3 + x + 1
  localparam logic [MisrWidth-1:0] PolyDefault = 16'h100B;

  // Last stimulus of a sweep; the edge that applies it moves the FSM to DONE.
  localparam logic [VecWidth-1:0] VecLast = '1;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StSweep = 2'b01,
    StDone  = 2'b10
  } sweep_state_e;

  // One MISR step: shift left, fold the feedback taps in on a carry-out, then
  // XOR in the zero-extended response word.
  function automatic logic [MisrWidth-1:0] misr_step(input logic [MisrWidth-1:0] sig,
                                                     input logic [RespWidth-1:0] din,
                                                     input logic [MisrWidth-1:0] poly);
    logic [MisrWidth-1:0] fb;
    fb = sig[MisrWidth-1] ? poly : '0;
    return {sig[MisrWidth-2:0], 1'b0} ^ fb ^ {{(MisrWidth - RespWidth){1'b0}}, din};
  endfunction

endpackage

// File: rtl/aig_vector_sweeper_if.sv
// Control, stimulus and result bundle between the sweeper and its host/circuit under test.
interface aig_vector_sweeper_if;
  import aig_sweep_pkg::*;

  logic                 start;
  logic                 abort;
  logic [MisrWidth-1:0] golden;
  logic [VecWidth-1:0]  vec;
  logic                 vec_valid;
  logic [RespWidth-1:0] resp;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [MisrWidth-1:0] signature;

  // Host / circuit-under-test side.
  modport master (
    output start, abort, golden, resp,
    input  vec, vec_valid, busy, done, pass, signature
  );

  // Sweeper side.
  modport slave (
    input  start, abort, golden, resp,
    output vec, vec_valid, busy, done, pass, signature
  );

endinterface

// File: rtl/aig_misr.sv
// 16-bit multiple-input signature register compacting 13-bit response words.
module aig_misr
  import aig_sweep_pkg::*;
#(
  parameter logic [MisrWidth-1:0] POLY = PolyDefault
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [MisrWidth-1:0] seed,
  input  logic                 en,
  input  logic [RespWidth-1:0] din,
  output logic [MisrWidth-1:0] sig
);

  logic [MisrWidth-1:0] sig_q, sig_d;

  // Next signature: load wins over compaction, otherwise hold.
  always_comb begin
    sig_d = sig_q;
    if (load) begin
      sig_d = seed;
    end else if (en) begin
      sig_d = misr_step(sig_q, din, POLY);
    end
  end

  // Signature register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/aig_vector_sweeper.sv
// Applies all 16 input vectors to a 4-in/13-out combinational block, compacts the
// responses in a MISR and compares the final signature against a golden value.
module aig_vector_sweeper
  import aig_sweep_pkg::*;
#(
  parameter logic [MisrWidth-1:0] SEED = 16'hFFFF,
  parameter logic [MisrWidth-1:0] POLY = PolyDefault
) (
  input logic                 clk,
  input logic                 rst,
  aig_vector_sweeper_if.slave bus
);

  sweep_state_e        state_q, state_d;
  logic [VecWidth-1:0] vec_q, vec_d;
  logic                pass_q, pass_d;
  logic                misr_load;
  logic                misr_en;
  logic [MisrWidth-1:0] sig;
  logic                sig_match;

  assign sig_match = (sig == bus.golden);

  // Next-state, stimulus counter and MISR control.
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    pass_d    = pass_q;
    misr_load = 1'b0;
    misr_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Abort outranks start so a simultaneous pair leaves the sweeper idle.
        if (bus.start && !bus.abort) begin
          state_d   = StSweep;
          vec_d     = '0;
          misr_load = 1'b1;
        end
      end
      StSweep: begin
        // Abort freezes the MISR before the current vector is compacted.
        if (bus.abort) begin
          state_d = StIdle;
        end else begin
          misr_en = 1'b1;
          vec_d   = vec_q + VecWidth'(1);
          if (vec_q == VecLast) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        pass_d  = sig_match;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM, stimulus and verdict registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      vec_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      pass_q  <= pass_d;
    end
  end

  aig_misr #(
    .POLY (POLY)
  ) u_misr (
    .clk  (clk),
    .rst  (rst),
    .load (misr_load),
    .seed (SEED),
    .en   (misr_en),
    .din  (bus.resp),
    .sig  (sig)
  );

  assign bus.vec       = vec_q;
  assign bus.vec_valid = (state_q == StSweep);
  assign bus.busy      = (state_q == StSweep);
  assign bus.done      = (state_q == StDone);
  // Live compare during DONE, then the registered verdict holds afterwards.
  assign bus.pass      = (state_q == StDone) ? sig_match : pass_q;
  assign bus.signature = sig;

endmodule

// File: tb/tb_aig_vector_sweeper.sv
// Directed bench: two sweepers, one seeded with 0 and driven by a pattern source,
// one seeded with 16'hFFFF and wired to a small AIG-style circuit model.
module tb_aig_vector_sweeper;
  import aig_sweep_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aig_vector_sweeper_if bus0 ();
  aig_vector_sweeper_if bus1 ();

  aig_vector_sweeper #(
    .SEED (16'h0000),
    .POLY (16'h100B)
  ) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  aig_vector_sweeper #(
    .SEED (16'hFFFF),
    .POLY (16'h100B)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int errors = 0;
  int checks = 0;

  logic       hit_en;
  logic [3:0] hit_vec;

  // Small AND/inverter network standing in for the circuit under test.
  function automatic logic [12:0] cut_eval(input logic [3:0] x);
    logic [12:0] f;
    f[0]  = x[0] & x[1];
    f[1]  = ~(x[2] & x[3]);
    f[2]  = x[0] & ~x[2];
    f[3]  = ~(~x[1] & ~x[3]);
    f[4]  = f[0] & f[1];
    f[5]  = ~(f[2] & f[3]);
    f[6]  = x[3] & ~f[0];
    f[7]  = ~(~f[5] & ~f[6]);
    f[8]  = x[1] & x[2];
    f[9]  = ~(f[8] & ~x[0]);
    f[10] = f[7] & f[9];
    f[11] = ~(f[0] & f[8] & x[3]);
    f[12] = f[10] & ~f[6];
    return f;
  endfunction

  // Reference signature of a full sweep of cut_eval from a given seed.
  function automatic logic [15:0] model_sig(input logic [15:0] seed);
    logic [15:0] s;
    s = seed;
    for (int v = 0; v < 16; v++) begin
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h100B : 16'h0000) ^ {3'b000, cut_eval(4'(v))};
    end
    return s;
  endfunction

  always_comb bus0.resp = (hit_en && bus0.vec == hit_vec) ? 13'h0001 : 13'h0000;
  always_comb bus1.resp = cut_eval(bus1.vec);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Full sweep on dut0 starting at a negedge; checks every vector, the done cycle and the held verdict.
  task automatic sweep0(input string tag, input logic [15:0] gold, input logic [15:0] exp_sig,
                        input logic exp_pass);
    bus0.golden = gold;
    bus0.start  = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check({tag, "_vec"}, 32'(bus0.vec), 32'(i));
      check({tag, "_valid_busy_done"}, {bus0.vec_valid, bus0.busy, bus0.done}, 3'b110);
      @(negedge clk);
    end
    check({tag, "_done_cycle17"}, {bus0.vec_valid, bus0.busy, bus0.done}, 3'b001);
    check({tag, "_sig"}, bus0.signature, exp_sig);
    check({tag, "_pass"}, bus0.pass, exp_pass);
    @(negedge clk);
    check({tag, "_after_done"}, {bus0.vec_valid, bus0.busy, bus0.done}, 3'b000);
    check({tag, "_pass_held"}, bus0.pass, exp_pass);
    check({tag, "_vec_wrap"}, bus0.vec, 4'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          n_valid;
    int          n_done;
    logic [15:0] msig;

    rst         = 1'b1;
    hit_en      = 1'b0;
    hit_vec     = 4'h0;
    bus0.start  = 1'b0;
    bus0.abort  = 1'b0;
    bus0.golden = 16'h0000;
    bus1.start  = 1'b0;
    bus1.abort  = 1'b0;
    bus1.golden = 16'h0000;
    repeat (2) @(negedge clk);

    // Reset values.
    check("rst_vec", bus0.vec, 4'h0);
    check("rst_flags", {bus0.vec_valid, bus0.busy, bus0.done, bus0.pass}, 4'b0000);
    check("rst_sig", bus0.signature, 16'h0000);
    rst = 1'b0;
    @(negedge clk);

    // Zero responses from a zero seed compact to zero.
    sweep0("zero", 16'h0000, 16'h0000, 1'b1);

    // Single response bit at the last / second-to-last vector.
    hit_en  = 1'b1;
    hit_vec = 4'hF;
    sweep0("hit15", 16'h0001, 16'h0001, 1'b1);
    hit_vec = 4'hE;
    sweep0("hit14", 16'h0002, 16'h0002, 1'b1);
    hit_en = 1'b0;

    // Restart pulses during SWEEP and start in DONE are ignored.
    bus0.golden = 16'h0000;
    bus0.start  = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    n_valid = 0;
    n_done  = 0;
    for (int k = 0; k < 24; k++) begin
      if (bus0.vec_valid) n_valid++;
      if (bus0.done) n_done++;
      bus0.start = (k == 3 || k == 10 || bus0.done);
      @(negedge clk);
    end
    bus0.start = 1'b0;
    check("restart_vectors", 32'(n_valid), 32'd16);
    check("restart_done_pulses", 32'(n_done), 32'd1);

    // Abort at vec=7 freezes the post-vec-6 signature (response bit at vec=5 -> 2).
    hit_en  = 1'b1;
    hit_vec = 4'h5;
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    repeat (7) @(negedge clk);
    check("abort_at_vec7", bus0.vec, 4'h7);
    bus0.abort = 1'b1;
    @(negedge clk);
    bus0.abort = 1'b0;
    check("abort_flags", {bus0.vec_valid, bus0.busy, bus0.done}, 3'b000);
    check("abort_sig", bus0.signature, 16'h0002);
    check("abort_pass_kept", bus0.pass, 1'b1);
    n_done = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus0.done) n_done++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    check("abort_sig_frozen", bus0.signature, 16'h0002);

    // Abort beats start in IDLE.
    bus0.start = 1'b1;
    bus0.abort = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    bus0.abort = 1'b0;
    check("abort_start_idle", {bus0.vec_valid, bus0.busy}, 2'b00);

    // Reset mid-sweep at vec=9.
    hit_vec    = 4'h2;
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    repeat (9) @(negedge clk);
    check("rst_at_vec9", bus0.vec, 4'h9);
    check("rst_pre_sig", bus0.signature, 16'h0040);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_vec", bus0.vec, 4'h0);
    check("midrst_flags", {bus0.vec_valid, bus0.busy, bus0.done, bus0.pass}, 4'b0000);
    check("midrst_sig", bus0.signature, 16'h0000);
    n_done = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus0.done) n_done++;
      @(negedge clk);
    end
    check("midrst_no_done", 32'(n_done), 32'd0);
    hit_en = 1'b0;

    // Model-wired sweeper against the software signature, then a corrupted golden.
    msig        = model_sig(16'hFFFF);
    bus1.golden = msig;
    bus1.start  = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    repeat (16) @(negedge clk);
    check("model_done", bus1.done, 1'b1);
    check("model_sig", bus1.signature, msig);
    check("model_pass", bus1.pass, 1'b1);
    @(negedge clk);
    check("model_pass_held", bus1.pass, 1'b1);

    bus1.golden = msig ^ 16'h0001;
    bus1.start  = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    repeat (16) @(negedge clk);
    check("badgold_done", bus1.done, 1'b1);
    check("badgold_pass", bus1.pass, 1'b0);
    @(negedge clk);
    check("badgold_pass_held", bus1.pass, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aig_vector_sweeper.md
AIG_VECTOR_SWEEPER -- requirements
Module: aig_vector_sweeper

Interface
REQ-001 SHALL have parameter SEED, default 16'hFFFF, MISR initial value loaded on each start.
REQ-002 SHALL have parameter POLY, default 16'h100B, MISR feedback taps (x^16+x^12+x^3+x+1).
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, single-cycle request to begin a sweep; honoured only in IDLE.
REQ-006 SHALL have port abort, input, 1, cancels a sweep in progress.
REQ-007 SHALL have port golden, input, 16, expected signature; sampled in the DONE cycle.
REQ-008 SHALL have port vec, output, 4, stimulus {x3,x2,x1,x0} driven to the 4-input/13-output combinational circuit under test.
REQ-009 SHALL have port vec_valid, output, 1, vec is a live stimulus this cycle.
REQ-010 SHALL have port resp, input, 13, responses {f13..f1} from the circuit under test, combinational from vec.
REQ-011 SHALL have port busy, output, 1, high in SWEEP.
REQ-012 SHALL have port done, output, 1, one-cycle pulse at sweep completion.
REQ-013 SHALL have port pass, output, 1, signature==golden; valid with done and held until the next start.
REQ-014 SHALL have port signature, output, 16, MISR contents.

Function
REQ-015 SHALL implement FSM states IDLE, SWEEP, DONE.
REQ-016 SHALL move IDLE->SWEEP on start; the same edge sets vec=0 and signature=SEED.
REQ-017 SHALL, in SWEEP, hold vec_valid=1 and busy=1 and sample resp in the same cycle vec is presented (zero-cycle DUT latency).
REQ-018 SHALL, on each SWEEP edge, update signature := {sig[14:0],1'b0} XOR (sig[15] ? POLY : 0) XOR {3'b000,resp}.
REQ-019 SHALL, on each SWEEP edge, increment vec modulo 16.
REQ-020 SHALL take exactly 16 SWEEP cycles (vec 0..15), then go to DONE on the edge that applies the vec=15 update; vec wraps to 0.
REQ-021 SHALL, in DONE, assert done=1 for one cycle, register pass=(signature==golden) on the exiting edge, and return to IDLE.
REQ-022 SHALL ignore start outside IDLE; start asserted in DONE is not queued.
REQ-023 SHALL, on abort in SWEEP, return to IDLE on the next edge with no done pulse; signature and pass keep their last values.
REQ-024 SHALL give abort priority when abort and start are both asserted in IDLE: stay in IDLE.
REQ-025 SHALL hold vec, signature and pass stable in IDLE; vec_valid=0 outside SWEEP.
REQ-026 SHALL produce latency from start to done of 17 cycles (16 SWEEP + 1 DONE).

Reset
REQ-027 SHALL, when rst=1 at an edge, set state=IDLE, vec=0, vec_valid=0, busy=0, done=0, pass=0, signature=16'h0000.
REQ-028 SHALL give rst priority over start and abort; rst mid-sweep discards the sweep with no done pulse.

Structure
REQ-029 SHALL place the FSM state enum, MISR width (16), vector width (4), response width (13) and the POLY default in a shared package aig_sweep_pkg.
REQ-030 SHALL implement the MISR as one sub-module, aig_misr (inputs clk, rst, load, seed, en, din; output sig).
REQ-031 SHALL fit in 120-400 lines of RTL.

Verification
REQ-032 SHALL verify: SEED=0, resp=0 throughout, start -> vec 0..15 over 16 cycles, done on cycle 17, signature=16'h0000, pass=1 with golden=0.
REQ-033 SHALL verify: SEED=0, resp=13'h0001 only when vec=15 -> signature=16'h0001; resp=13'h0001 only when vec=14 -> 16'h0002.
REQ-034 SHALL verify: a start pulse repeated during SWEEP -> still exactly 16 vectors and one done pulse.
REQ-035 SHALL verify: abort at vec=7 -> IDLE next cycle, busy=0, no done pulse, signature frozen at its post-vec-6 value.
REQ-036 SHALL verify: rst at vec=9 -> next cycle all outputs at their reset values, including signature=0.
REQ-037 SHALL verify: the DUT model is wired to vec/resp and golden is set to the software-model signature (SEED=16'hFFFF) -> pass=1; flipping golden bit 0 -> pass=0.
